// File: rtl/array_mux_arb.sv
// array_mux_arb: registered N-channel array selector with explicit-select or round-robin grant.
// One output register stage with valid/ready on both sides; arrays always move whole.
module array_mux_arb #(
    parameter int BITS     = 8,
    parameter int ELEMS    = 4,
    parameter int CHANNELS = 2,
    parameter int MODE     = 0,
    localparam int SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITS-1:0]     in_data [CHANNELS][ELEMS],
    input  logic [CHANNELS-1:0] in_valid,
    output logic [CHANNELS-1:0] in_ready,
    input  logic [SW-1:0]       sel,
    output logic [BITS-1:0]     out_data [ELEMS],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SW-1:0]       out_chan
);
    logic [BITS-1:0] data_q [ELEMS];
    logic [SW-1:0]   chan_q, rr_q, rr_d, g, idx;
    logic            valid_q, valid_d, gnt, take;
    // Scan from the far end so the first valid channel in priority order wins.
    always_comb begin
        g = '0;
        gnt = 1'b0;
        idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            idx = (MODE == 0) ? SW'(i) : SW'((int'(rr_q) + i) % CHANNELS);
            if (in_valid[idx] && (MODE != 0 || idx == sel)) begin
                gnt = 1'b1;
                g = idx;
            end
        end
        take = gnt && (!valid_q || out_ready) && !rst;
        in_ready = take ? CHANNELS'(1) << g : '0;
        valid_d = take || (valid_q && !out_ready);
        rr_d = (MODE != 0 && take) ? ((32'(g) == CHANNELS - 1) ? '0 : g + 1'b1) : rr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            chan_q <= '0;
            rr_q <= '0;
            for (int e = 0; e < ELEMS; e++) data_q[e] <= '0;
        end else begin
            valid_q <= valid_d;
            rr_q <= rr_d;
            if (take) begin
                data_q <= in_data[g];
                chan_q <= g;
            end
        end
    end
    assign out_data = data_q;
    assign out_valid = valid_q;
    assign out_chan = chan_q;
endmodule

// File: tb/tb_array_mux_arb.sv
// tb_array_mux_arb: three configurations (sel/2ch, rr/4ch, sel/3ch) against a per-cycle model.
module tb_array_mux_arb;
    localparam int CH[3] = '{2, 4, 3};
    localparam int MD[3] = '{0, 1, 0};
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [7:0] din [3][4][4];
    logic [3:0] vld [3];
    logic [1:0] sel_v [3];
    logic       ordy [3];
    logic [7:0] d0 [2][4], d1 [4][4], d2 [3][4];
    logic [7:0] od [3][4];
    logic       ov [3];
    logic [1:0] oc [3];
    logic [3:0] ir [3];
    logic       oc0;
    logic [1:0] oc1, oc2;
    logic [1:0] ir0;
    logic [3:0] ir1;
    logic [2:0] ir2;
    always_comb begin
        for (int c = 0; c < 2; c++) for (int e = 0; e < 4; e++) d0[c][e] = din[0][c][e];
        for (int c = 0; c < 4; c++) for (int e = 0; e < 4; e++) d1[c][e] = din[1][c][e];
        for (int c = 0; c < 3; c++) for (int e = 0; e < 4; e++) d2[c][e] = din[2][c][e];
    end
    assign oc[0] = {1'b0, oc0};
    assign oc[1] = oc1;
    assign oc[2] = oc2;
    assign ir[0] = {2'b0, ir0};
    assign ir[1] = ir1;
    assign ir[2] = {1'b0, ir2};
    array_mux_arb #(.BITS(8), .ELEMS(4), .CHANNELS(2), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(vld[0][1:0]), .in_ready(ir0),
        .sel(sel_v[0][0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_chan(oc0));
    array_mux_arb #(.BITS(8), .ELEMS(4), .CHANNELS(4), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(vld[1]), .in_ready(ir1),
        .sel(sel_v[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_chan(oc1));
    array_mux_arb #(.BITS(8), .ELEMS(4), .CHANNELS(3), .MODE(0)) u2 (
        .clk(clk), .rst(rst), .in_data(d2), .in_valid(vld[2][2:0]), .in_ready(ir2),
        .sel(sel_v[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_chan(oc2));
    int checks = 0, fails = 0;
    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask
    // Model: one held array per configuration plus its round-robin start point.
    bit         mv [3] = '{0, 0, 0};
    logic [7:0] md [3][4];
    int         mc [3] = '{0, 0, 0};
    int         mr [3] = '{0, 0, 0};
    initial for (int k = 0; k < 3; k++) for (int e = 0; e < 4; e++) md[k][e] = 8'd0;
    function automatic int xg(int k);
        int s, c;
        if (rst || (mv[k] && !ordy[k])) return -1;
        if (MD[k] == 0) begin
            s = (k == 0) ? int'(sel_v[k][0]) : int'(sel_v[k]);
            return (s < CH[k] && vld[k][s]) ? s : -1;
        end
        for (int i = 0; i < CH[k]; i++) begin
            c = (mr[k] + i) % CH[k];
            if (vld[k][c]) return c;
        end
        return -1;
    endfunction
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int g;
            g = xg(k);
            if (rst) begin
                mv[k] = 0; mc[k] = 0; mr[k] = 0;
                for (int e = 0; e < 4; e++) md[k][e] = 8'd0;
            end else if (g >= 0) begin
                mv[k] = 1; mc[k] = g;
                for (int e = 0; e < 4; e++) md[k][e] = din[k][g][e];
                if (MD[k] == 1) mr[k] = (g + 1) % CH[k];
            end else if (ordy[k]) mv[k] = 0;
        end
    end
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int g;
                g = xg(k);
                chk($sformatf("k%0d out_valid", k), 32'(ov[k]), 32'(mv[k]));
                chk($sformatf("k%0d out_chan", k), 32'(oc[k]), 32'(mc[k]));
                chk($sformatf("k%0d in_ready", k), 32'(ir[k]), (g >= 0) ? 32'(1) << g : 32'(0));
                for (int e = 0; e < 4; e++)
                    chk($sformatf("k%0d out_data[%0d]", k, e), 32'(od[k][e]), 32'(md[k][e]));
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic fill(int t);
        for (int k = 0; k < 3; k++) for (int c = 0; c < 4; c++) for (int e = 0; e < 4; e++)
            din[k][c][e] = 8'(((t & 15) << 4) | (c << 2) | e);
    endtask
    initial begin
        fill(1);
        for (int k = 0; k < 3; k++) begin
            vld[k] = (k == 1) ? 4'hf : (k == 0 ? 4'h3 : 4'h7);
            sel_v[k] = 2'd1;
            ordy[k] = 1'b1;
        end
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("T1 k%0d in_ready in rst", k), 32'(ir[k]), 0);
            chk($sformatf("T1 k%0d out_valid in rst", k), 32'(ov[k]), 0);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("T1 k%0d out_chan", k), 32'(oc[k]), 0);
            chk($sformatf("T1 k%0d out_data[0]", k), 32'(od[k][0]), 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) vld[k] = 4'h0;
        step();
        vld[0] = 4'b0011;
        for (int e = 0; e < 4; e++) din[0][1][e] = 8'(e + 1);
        #1 chk("T2 in_ready", 32'(ir[0]), 2);
        step();
        for (int e = 0; e < 4; e++) chk($sformatf("T2 out_data[%0d]", e), 32'(od[0][e]), 32'(e + 1));
        chk("T2 out_chan", 32'(oc[0]), 1);
        ordy[0] = 1'b0;
        for (int e = 0; e < 4; e++) din[0][1][e] = 8'(e + 9);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("T3 in_ready held", 32'(ir[0]), 0);
            chk("T3 out_data held", 32'(od[0][3]), 4);
        end
        ordy[0] = 1'b1;
        #1 chk("T3 in_ready release", 32'(ir[0]), 2);
        step();
        chk("T3 replaced data", 32'(od[0][0]), 9);
        chk("T3 valid kept", 32'(ov[0]), 1);
        vld[0] = 4'h0;
        step();
        chk("T3 drained", 32'(ov[0]), 0);
        chk("T3 data held after drain", 32'(od[0][3]), 12);
        vld[1] = 4'hf;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("T4 rr chan %0d", i), 32'(oc[1]), 32'(i % 4));
        end
        vld[1] = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("T5 wrap chan %0d", i), 32'(oc[1]), (i == 1) ? 3 : 0);
        end
        vld[1] = 4'h0;
        sel_v[2] = 2'd3;
        vld[2] = 4'b0111;
        #1 chk("T6 sel out of range ready", 32'(ir[2]), 0);
        step();
        step();
        chk("T6 sel out of range valid", 32'(ov[2]), 0);
        sel_v[2] = 2'd2;
        step();
        chk("T6 sel2 valid", 32'(ov[2]), 1);
        chk("T6 sel2 chan", 32'(oc[2]), 2);
        ordy[2] = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("T6 rst drops held", 32'(ov[2]), 0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            fill(i + 2);
            vld[0] = 4'((i * 3) % 4);
            vld[1] = 4'((i * 7 + 3) % 16);
            vld[2] = 4'((i * 5) % 8);
            sel_v[0] = 2'(i % 2);
            sel_v[1] = 2'(i % 4);
            sel_v[2] = 2'((i / 2) % 4);
            for (int k = 0; k < 3; k++) ordy[k] = ((i + k) % 3) != 0;
            rst = (i == 20);
            step();
        end
        rst = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
